// File: rtl/instr_fetch.sv
// Fetch stage: issues a two-word imem read and presents {opcode,imm} over valid/ready.
// Optional FETCH_TIMEOUT_EN adds a WAIT watchdog that raises a sticky fetch_err.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pointer,
  output logic        imem_req,
  output logic [15:0] imem_addr0,
  output logic [15:0] imem_addr1,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata0,
  input  logic [15:0] imem_rdata1,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pointer,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pc1_q, pc1_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc1_d   = pc1_q;
    req_d   = req_q;
    valid_d = valid_q;
    instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_REQ: begin
        // A grant only counts while the request is actually visible.
        if (req_q && imem_gnt) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          req_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_HOLD;
          valid_d = 1'b1;
          instr_d = {imem_rdata0, imem_rdata1};
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_REQ;
          req_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_HOLD: begin
        if (instr_ready) begin
          state_d = S_REQ;
          valid_d = 1'b0;
          req_d   = 1'b1;
          pc_d    = next_pointer[31:16];
          pc1_d   = next_pointer[15:0];
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      pc1_q   <= RESET_PC + 16'd1;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc1_q   <= pc1_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign imem_req      = req_q;
  assign imem_addr0    = pc_q;
  assign imem_addr1    = pc1_q;
  assign instr_valid   = valid_q;
  assign instruction   = instr_q;
  assign instr_pointer = {16'h0000, pc_q};

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT == 0);
  assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scenario tests for instr_fetch with a queue of expected {instruction,pointer}.
// The timeout scenario is built only when FETCH_TIMEOUT_EN is defined.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] next_pointer = '0;
  logic        imem_req;
  logic [15:0] imem_addr0;
  logic [15:0] imem_addr1;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata0 = '0;
  logic [15:0] imem_rdata1 = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instr_pointer;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [15:0] model_pc = 16'h0000;

  instr_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .next_pointer (next_pointer),
    .imem_req     (imem_req),
    .imem_addr0   (imem_addr0),
    .imem_addr1   (imem_addr1),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata0  (imem_rdata0),
    .imem_rdata1  (imem_rdata1),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instruction  (instruction),
    .instr_pointer(instr_pointer),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mem0(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] mem1(input logic [15:0] a);
    return a + 16'h1234;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({imem_req, instr_valid, fetch_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got %b want 000",
               {imem_req, instr_valid, fetch_err});
    end
    checks++;
    if (instruction !== 32'h0) begin
      errors++;
      $display("FAIL reset_instr got %h want 0", instruction);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({imem_req, imem_addr0, imem_addr1} !== {1'b1, 16'h0000, 16'h0001}) begin
      errors++;
      $display("FAIL first_req got %b %h %h want 1 0000 0001",
               imem_req, imem_addr0, imem_addr1);
    end
    model_pc = 16'h0000;
  endtask

  task automatic test_basic_and_stall();
    logic [63:0] e;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    checks++;
    if ({imem_req, instr_valid} !== 2'b00) begin
      errors++;
      $display("FAIL wait_ctl got %b want 00", {imem_req, instr_valid});
    end
    imem_rvalid = 1'b1;
    imem_rdata0 = 16'h4123;
    imem_rdata1 = 16'h00AA;
    exp_q.push_back({32'h412300AA, 32'h0});
    tick();
    imem_rvalid = 1'b0;
    imem_rdata0 = '0;
    imem_rdata1 = '0;
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_valid got %b want 1", instr_valid);
    end
    e = '0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL basic_sb got empty want entry");
    end else begin
      e = exp_q.pop_front();
      if ({instruction, instr_pointer} !== e) begin
        errors++;
        $display("FAIL basic_data got %h %h want %h",
                 instruction, instr_pointer, e);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({instr_valid, imem_req, instruction, instr_pointer} !==
          {2'b10, e}) begin
        errors++;
        $display("FAIL stall_%0d got %b%b %h %h want 10 %h", i,
                 instr_valid, imem_req, instruction, instr_pointer, e);
      end
    end
    instr_ready  = 1'b1;
    next_pointer = 32'h0010_0011;
    tick();
    instr_ready  = 1'b0;
    next_pointer = 32'hDEAD_BEEF;
    model_pc = 16'h0010;
    checks++;
    if ({instr_valid, imem_req, imem_addr0, imem_addr1} !==
        {2'b01, 16'h0010, 16'h0011}) begin
      errors++;
      $display("FAIL consume got %b%b %h %h want 01 0010 0011",
               instr_valid, imem_req, imem_addr0, imem_addr1);
    end
  endtask

  task automatic test_gnt_wait();
    logic [63:0] e;
    for (int i = 0; i < 3; i++) begin
      imem_rvalid = (i == 1);
      tick();
      checks++;
      if ({imem_req, instr_valid, imem_addr0, imem_addr1} !==
          {2'b10, model_pc, model_pc + 16'd1}) begin
        errors++;
        $display("FAIL gnt_hold_%0d got %b%b %h %h want 10 %h", i,
                 imem_req, instr_valid, imem_addr0, imem_addr1, model_pc);
      end
    end
    imem_rvalid = 1'b0;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL early_valid_%0d got %b want 0", i, instr_valid);
      end
    end
    imem_rvalid = 1'b1;
    imem_rdata0 = mem0(model_pc);
    imem_rdata1 = mem1(model_pc + 16'd1);
    exp_q.push_back({mem0(model_pc), mem1(model_pc + 16'd1),
                     16'h0000, model_pc});
    tick();
    imem_rvalid = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL gw_sb got empty want entry");
    end else begin
      e = exp_q.pop_front();
      if ({instr_valid, instruction, instr_pointer} !== {1'b1, e}) begin
        errors++;
        $display("FAIL gw_data got %b %h %h want 1 %h",
                 instr_valid, instruction, instr_pointer, e);
      end
    end
    instr_ready  = 1'b1;
    next_pointer = 32'hFFFF_0000;
    tick();
    instr_ready = 1'b0;
    model_pc = 16'hFFFF;
    checks++;
    if ({imem_req, imem_addr0, imem_addr1} !== {1'b1, 16'hFFFF, 16'h0000}) begin
      errors++;
      $display("FAIL wrap got %b %h %h want 1 ffff 0000",
               imem_req, imem_addr0, imem_addr1);
    end
  endtask

  task automatic test_reset_in_wait();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata0 = 16'h1111;
    imem_rdata1 = 16'h2222;
    tick();
    imem_rvalid = 1'b0;
    model_pc = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({instr_valid, imem_req, imem_addr0, imem_addr1} !==
          {2'b01, 16'h0000, 16'h0001}) begin
        errors++;
        $display("FAIL rst_wait_%0d got %b%b %h %h want 01 0000 0001", i,
                 instr_valid, imem_req, imem_addr0, imem_addr1);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    logic [15:0] np;
    for (int n = 0; n < 6; n++) begin
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
      imem_rvalid = 1'b1;
      imem_rdata0 = mem0(model_pc);
      imem_rdata1 = mem1(model_pc + 16'd1);
      exp_q.push_back({mem0(model_pc), mem1(model_pc + 16'd1),
                       16'h0000, model_pc});
      tick();
      imem_rvalid = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_sb_%0d got empty want entry", n);
      end else begin
        e = exp_q.pop_front();
        if ({instr_valid, instruction, instr_pointer} !== {1'b1, e}) begin
          errors++;
          $display("FAIL b2b_data_%0d got %b %h %h want 1 %h", n,
                   instr_valid, instruction, instr_pointer, e);
        end
      end
      np = 16'($urandom_range(0, 65535));
      instr_ready  = 1'b1;
      next_pointer = {np, np + 16'd1};
      tick();
      instr_ready = 1'b0;
      model_pc = np;
      checks++;
      if ({instr_valid, imem_req, imem_addr0, imem_addr1} !==
          {2'b01, np, np + 16'd1}) begin
        errors++;
        $display("FAIL b2b_next_%0d got %b%b %h %h want 01 %h", n,
                 instr_valid, imem_req, imem_addr0, imem_addr1, np);
      end
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if ({fetch_err, imem_req} !== 2'b00) begin
        errors++;
        $display("FAIL to_early_%0d got %b want 00", i, {fetch_err, imem_req});
      end
    end
    tick();
    checks++;
    if ({fetch_err, imem_req, imem_addr0} !== {2'b11, model_pc}) begin
      errors++;
      $display("FAIL timeout got %b%b %h want 11 %h",
               fetch_err, imem_req, imem_addr0, model_pc);
    end
    tick();
    checks++;
    if (fetch_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b want 1", fetch_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_and_stall();
    test_gnt_wait();
    test_reset_in_wait();
    test_back_to_back();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`else
    checks++;
    if (fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL err_tied got %b want 0", fetch_err);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
